scroll_controller: RTL and testbench
====================================

# scroll_controller

Upstream scroll/progress generator for the side-scrolling level. Counts frame ticks in the `Clk` domain while the player holds "right" past the scroll threshold, and produces the 9-bit `BG_step` level-progress value. `BG_step` is consumed by the background renderer and all sprite stages (mario, items, ending), which gate visibility on it. It also produces a sub-step pixel offset and a level-complete flag.

## Interface
- `STEP_MAX`, 300: terminal `BG_step` value; level complete when reached.
- `X_THRESH`, 320: minimum `mario_X_Pos` for scrolling to occur.
- `SPEED`, 2: pixels added to the fine offset per eligible frame tick; legal range 1..15.
- `Clk` input, 1 bit: 50 MHz system clock.
- `Reset` input, 1 bit: asynchronous, active-high.
- `frame_clk` input, 1 bit: vertical-sync-rate frame strobe, asynchronous to `Clk`.
- `keycode` input, 32 bits: four 8-bit USB key slots, `[31:24]`..`[7:0]`.
- `mario_X_Pos` input, 10 bits: player screen X position.
- `freeze` input, 1 bit: pause; while high, no state or counter changes on ticks.
- `BG_step` output, 9 bits: level progress in 16-pixel steps.
- `fine_x` output, 4 bits: pixel offset within the current step, 0..15.
- `scrolling` output, 1 bit: high for the frame following a tick that advanced scroll.
- `level_done` output, 1 bit: high once `BG_step` reaches `STEP_MAX`; sticky until reset.

## Operation
- Clock and reset: one clock, `Clk`. `Reset` is asynchronous and active-high.
- Frame sync:
  - `frame_clk` passes through a 2-flop synchronizer, `s1` then `s2`, plus a history flop `s3`.
  - `tick` = `s2 & ~s3`: one `Clk` cycle per `frame_clk` rising edge.
- Key decode is evaluated at each tick:
  - `right_on` = any slot == 8'h07.
  - `left_on` = any slot == 8'h04.
- `eligible` = `right_on & ~left_on & (mario_X_Pos >= X_THRESH)`.
- State machine: IDLE, RUN, FINISH. Transitions occur only on `tick & ~freeze`.
  - IDLE → RUN when `right_on`. No scroll occurs on the transition tick.
  - RUN, when `eligible`:
    - `sum = fine_x + SPEED` (5-bit).
    - If `sum >= 16`: `fine_x <= sum - 16` and `BG_step <= BG_step + 1`.
    - Otherwise: `fine_x <= sum`.
    - `scrolling <= 1`.
  - RUN, when not `eligible`: `scrolling <= 0`; counters hold.
  - RUN → FINISH on the same tick that `BG_step` becomes `STEP_MAX`:
    - `fine_x` forced to 0.
    - `level_done <= 1`.
  - FINISH is absorbing until `Reset`:
    - `BG_step` = `STEP_MAX`, `fine_x` = 0, `scrolling` = 0, `level_done` = 1.
- `BG_step` never exceeds `STEP_MAX`, never decrements, and never wraps.
- Both direction keys held: treated as not eligible.
- `freeze` high on a tick:
  - Tick ignored entirely, including state transitions.
  - `scrolling` is cleared.
- Keycodes other than 8'h07 and 8'h04 are ignored.

## Timing
- Reset values (all asynchronous on `Reset`):
  - Outputs: `BG_step` = 0, `fine_x` = 0, `scrolling` = 0, `level_done` = 0.
  - State: IDLE.
  - Synchronizer: `s1`, `s2`, `s3` = 0.
- Latency: a `frame_clk` rise meeting setup before `Clk` edge E0 updates the outputs at edge E2.
  - E0 captures into `s1`.
  - E1 captures into `s2`; `tick` is high during the following cycle.
  - E2 updates the registers.
- `frame_clk` held high produces exactly one tick. A new tick requires a low level seen by `s2` for at least one cycle.
- `keycode`, `mario_X_Pos` and `freeze` are sampled only in the tick cycle. Changes between ticks have no effect.
- All outputs are registered and glitch-free. They are stable for the whole frame between ticks.
- `Reset` asserted mid-RUN or in FINISH returns everything to the reset values immediately, with no wait for a clock edge.
- Operation resumes from IDLE on the first tick after deassertion. A tick pending in the synchronizer at deassertion is lost.

## Test plan
- Reset values: assert `Reset` with random inputs → `BG_step` = 0, `fine_x` = 0, `scrolling` = 0, `level_done` = 0. Hold 10 `frame_clk` pulses with no keys → no change.
- Start and scroll:
  - Stimulus: `keycode` = 32'h00000007, `mario_X_Pos` = 320, default `SPEED`, 9 `frame_clk` pulses.
  - Required: first pulse moves IDLE→RUN with `fine_x` = 0; after 8 more pulses `BG_step` = 1, `fine_x` = 0, `scrolling` = 1.
  - Latency: the `BG_step` update lands 3 `Clk` edges after the final rise.
- Threshold and conflicts, all in RUN with outputs checked unchanged and `scrolling` = 0:
  - `mario_X_Pos` = 319 with right held.
  - `keycode` = 32'h00040700, both keys held.
  - `freeze` = 1 with right held.
- Saturation:
  - Stimulus: start with `BG_step` = 299 and `fine_x` = 14 by driving pulses, then apply one eligible tick.
  - Required: `BG_step` = 300, `fine_x` = 0, `level_done` = 1.
  - Continue with 20 more eligible ticks → `BG_step` stays 300 and `scrolling` = 0.
- Strobe and reset:
  - `frame_clk` held high for 1000 cycles → exactly one advance.
  - Assert `Reset` asynchronously mid-cycle while in FINISH → outputs go to reset values before the next `Clk` edge.

Source files
------------

// File: rtl/scroll_controller.sv
// Frame-tick driven scroll/progress generator: synchronizes frame_clk into Clk,
// advances fine_x/BG_step while the player holds right past the threshold.
module scroll_controller #(
  parameter int unsigned STEP_MAX = 300,
  parameter int unsigned X_THRESH = 320,
  parameter int unsigned SPEED    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  input  logic [9:0]  mario_X_Pos,
  input  logic        freeze,
  output logic [8:0]  BG_step,
  output logic [3:0]  fine_x,
  output logic        scrolling,
  output logic        level_done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [8:0]  step_q;
  logic [3:0]  fine_q;
  logic        scroll_q;
  logic        done_q;

  logic        tick;
  logic        right_on, left_on, eligible;
  logic [4:0]  sum_d;
  logic [8:0]  step_d;
  logic        hit_max;

  assign tick = s2_q & ~s3_q;

  always_comb begin
    right_on = 1'b0;
    left_on  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == 8'h07) right_on = 1'b1;
      if (keycode[8*i +: 8] == 8'h04) left_on  = 1'b1;
    end
    eligible = right_on & ~left_on & (mario_X_Pos >= 10'(X_THRESH));
    sum_d    = {1'b0, fine_q} + 5'(SPEED);
    step_d   = step_q + 9'd1;
    hit_max  = sum_d[4] && (step_d == 9'(STEP_MAX));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      step_q   <= '0;
      fine_q   <= '0;
      scroll_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (tick) begin
        if (freeze) begin
          scroll_q <= 1'b0;
        end else begin
          case (state_q)
            IDLE: begin
              if (right_on) state_q <= RUN;
            end
            RUN: begin
              if (!eligible) begin
                scroll_q <= 1'b0;
              end else if (hit_max) begin
                // Terminal step: snap to a clean FINISH output set on this same tick.
                state_q  <= FINISH;
                step_q   <= step_d;
                fine_q   <= '0;
                scroll_q <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                fine_q   <= sum_d[3:0];
                scroll_q <= 1'b1;
                if (sum_d[4]) step_q <= step_d;
              end
            end
            FINISH: begin
              scroll_q <= 1'b0;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign BG_step    = step_q;
  assign fine_x     = fine_q;
  assign scrolling  = scroll_q;
  assign level_done = done_q;

endmodule

// File: tb/tb_scroll_controller.sv
// Directed self-checking bench for scroll_controller with default parameters.
module tb_scroll_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [31:0] keycode;
  logic [9:0]  mario_X_Pos;
  logic        freeze;
  logic [8:0]  BG_step;
  logic [3:0]  fine_x;
  logic        scrolling;
  logic        level_done;

  int checks   = 0;
  int failures = 0;

  scroll_controller #(.STEP_MAX(300), .X_THRESH(320), .SPEED(2)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .mario_X_Pos(mario_X_Pos),
    .freeze     (freeze),
    .BG_step    (BG_step),
    .fine_x     (fine_x),
    .scrolling  (scrolling),
    .level_done (level_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int step, input int fine,
                           input int scr, input int done);
    check({tag, ".step"},   32'(BG_step),    32'(step));
    check({tag, ".fine"},   32'(fine_x),     32'(fine));
    check({tag, ".scroll"}, 32'(scrolling),  32'(scr));
    check({tag, ".done"},   32'(level_done), 32'(done));
  endtask

  // One frame_clk pulse, driven and released on falling Clk edges.
  task automatic pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  initial begin
    Reset       = 1'b1;
    frame_clk   = 1'($urandom);
    keycode     = $urandom;
    mario_X_Pos = 10'($urandom);
    freeze      = 1'($urandom);
    repeat (3) @(negedge Clk);
    check_out("reset", 0, 0, 0, 0);

    frame_clk   = 1'b0;
    keycode     = '0;
    mario_X_Pos = 10'd320;
    freeze      = 1'b0;
    @(negedge Clk) Reset = 1'b0;
    pulses(10);
    check_out("idle_nokeys", 0, 0, 0, 0);

    keycode = 32'h00000007;
    pulse();
    check_out("idle_to_run", 0, 0, 0, 0);
    pulses(7);
    check_out("run7", 0, 14, 1, 0);

    // Latency: the 8th scroll tick lands on the third rising edge after the rise.
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk) #1 check("lat.e0", 32'(BG_step), 32'd0);
    @(posedge Clk) #1 check("lat.e1", 32'(BG_step), 32'd0);
    @(posedge Clk) #1 check_out("lat.e2", 1, 0, 1, 0);
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    mario_X_Pos = 10'd319;
    pulse();
    check_out("below_thresh", 1, 0, 0, 0);

    mario_X_Pos = 10'd320;
    keycode     = 32'h07000000;
    pulse();
    check_out("slot3_right", 1, 2, 1, 0);

    keycode = 32'h00040700;
    pulse();
    check_out("both_keys", 1, 2, 0, 0);

    keycode     = 32'h00050700;
    mario_X_Pos = 10'd1023;
    pulse();
    check_out("other_keys", 1, 4, 1, 0);

    freeze = 1'b1;
    pulse();
    check_out("freeze", 1, 4, 0, 0);
    freeze = 1'b0;

    keycode     = 32'h00000007;
    mario_X_Pos = 10'd320;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (1000) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    check_out("held_high", 1, 6, 1, 0);

    // From step 1 / fine 6 to step 299 / fine 14: 4776 pixels at 2 per tick.
    pulses(2388);
    check_out("pre_max", 299, 14, 1, 0);
    pulse();
    check("max.step", 32'(BG_step),    32'd300);
    check("max.fine", 32'(fine_x),     32'd0);
    check("max.done", 32'(level_done), 32'd1);
    pulses(20);
    check_out("saturated", 300, 0, 0, 1);

    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check_out("async_reset", 0, 0, 0, 0);
    @(negedge Clk) Reset = 1'b0;
    pulse();
    check_out("restart_idle", 0, 0, 0, 0);
    pulse();
    check_out("restart_run", 0, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
